// File: rtl/intel8088_hold_arbiter_pkg.sv
// Shared definitions for the 8088 HOLD/HLDA bus arbiter.
//   arb_state_e      : arbiter FSM state encoding (2 bits)
//   NReqDefault      : default requester count
//   MaxBurstDefault  : default burst limit (only used with HOLD_BURST_LIMIT_EN)
package intel8088_arb_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReqHold = 2'd1,
    StGrant   = 2'd2,
    StRelease = 2'd3
  } arb_state_e;

  localparam int unsigned NReqDefault     = 4;
  localparam int unsigned MaxBurstDefault = 16;

endpackage

// File: rtl/intel8088_hold_arbiter_if.sv
// Bus-side signal bundle of the 8088 HOLD/HLDA arbiter.
//   req       : per-requester level request
//   HLDA      : hold acknowledge from the 8088
//   HOLD      : hold request to the 8088
//   gnt       : one-hot grant
//   owner     : index of current/last grantee
//   bus_busy  : arbiter not idle
//   proto_err : sticky HLDA protocol violation
// Modports: slave = arbiter side, master = requesters/CPU side.
interface intel8088_hold_arbiter_if #(
  parameter int unsigned NREQ = 4
) ();

  logic [NREQ-1:0]         req;
  logic                    HLDA;
  logic                    HOLD;
  logic [NREQ-1:0]         gnt;
  logic [$clog2(NREQ)-1:0] owner;
  logic                    bus_busy;
  logic                    proto_err;

  modport slave (
    input  req,
    input  HLDA,
    output HOLD,
    output gnt,
    output owner,
    output bus_busy,
    output proto_err
  );

  modport master (
    output req,
    output HLDA,
    input  HOLD,
    input  gnt,
    input  owner,
    input  bus_busy,
    input  proto_err
  );

endinterface

// File: rtl/intel8088_hold_arbiter_rr_picker.sv
// Combinational round-robin selector.
//   req_i    : request vector
//   ptr_i    : highest-priority index for this pick
//   valid_o  : at least one request is set
//   winner_o : first set request at or after ptr_i, wrapping
module rr_picker #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic                    valid_o,
  output logic [$clog2(NREQ)-1:0] winner_o
);

  localparam int unsigned PtrW = $clog2(NREQ);

  logic [PtrW-1:0] idx;

  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PtrW'((32'(ptr_i) + i) % NREQ);
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/intel8088_hold_arbiter.sv
// Intel 8088 minimum-mode HOLD/HLDA bus arbiter for NREQ bus masters.
// Raises HOLD on any request, waits for HLDA, grants one requester in
// round-robin order and returns the bus to the CPU after each tenure.
//   CLK    : bus clock, rising edge
//   RESET  : synchronous active-high reset
//   bus_io : slave modport of intel8088_hold_arbiter_if (req/HLDA in,
//            HOLD/gnt/owner/bus_busy/proto_err out)
// Optional feature: define HOLD_BURST_LIMIT_EN to cap each tenure at
// MAX_BURST grant cycles.
module intel8088_hold_arbiter
  import intel8088_arb_pkg::*;
#(
  parameter int unsigned NREQ      = NReqDefault,
  parameter int unsigned MAX_BURST = MaxBurstDefault
) (
  input logic                     CLK,
  input logic                     RESET,
  intel8088_hold_arbiter_if.slave bus_io
);

  localparam int unsigned PtrW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || MAX_BURST < 2) begin : g_param_check
    $error("intel8088_hold_arbiter: NREQ must be 2..8 and MAX_BURST >= 2");
  end

  arb_state_e      state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] owner_q, owner_d;
  logic            proto_err_q, proto_err_d;
  logic            hold_q, hold_d;
  logic [NREQ-1:0] gnt_q, gnt_d;

  logic            pick_valid;
  logic [PtrW-1:0] pick_idx;
  logic            burst_done;

  rr_picker #(
    .NREQ(NREQ)
  ) u_rr_picker (
    .req_i    (bus_io.req),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .winner_o (pick_idx)
  );

`ifdef HOLD_BURST_LIMIT_EN
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter sits at zero outside GRANT, so it is clear on every GRANT entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == StGrant) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // cnt_q counts completed grant cycles; this cycle is the MAX_BURST-th.
  assign burst_done = (cnt_q == CntW'(MAX_BURST - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign burst_done = 1'b0;
`endif

  // State register (plus registered outputs derived from next state).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      proto_err_q <= 1'b0;
      hold_q      <= 1'b0;
      gnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      proto_err_q <= proto_err_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    proto_err_d = proto_err_q;
    unique case (state_q)
      StIdle: begin
        if (|bus_io.req) begin
          state_d = StReqHold;
        end
      end
      StReqHold: begin
        if (bus_io.HLDA) begin
          if (pick_valid) begin
            state_d = StGrant;
            owner_d = pick_idx;
            ptr_d   = (pick_idx == PtrW'(NREQ - 1)) ? '0 : pick_idx + PtrW'(1);
          end else begin
            // Every requester withdrew before HLDA came back.
            state_d = StRelease;
          end
        end
      end
      StGrant: begin
        if (!bus_io.HLDA) begin
          proto_err_d = 1'b1;
          state_d     = StRelease;
        end else if (!bus_io.req[owner_q] || burst_done) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        // HOLD stays low until the CPU has visibly taken the bus back.
        if (!bus_io.HLDA) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from next state, registered above so HOLD/gnt are glitch-free.
  always_comb begin
    hold_d = (state_d == StReqHold) || (state_d == StGrant);
    gnt_d  = '0;
    if (state_d == StGrant) begin
      gnt_d[owner_d] = 1'b1;
    end
  end

  assign bus_io.HOLD      = hold_q;
  assign bus_io.gnt       = gnt_q;
  assign bus_io.owner     = owner_q;
  assign bus_io.bus_busy  = (state_q != StIdle);
  assign bus_io.proto_err = proto_err_q;

endmodule

// File: tb/tb_intel8088_hold_arbiter.sv
// Self-checking bench for intel8088_hold_arbiter (NREQ=4, MAX_BURST=4).
module tb_intel8088_hold_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  intel8088_hold_arbiter_if #(.NREQ(4)) bus_if ();

  intel8088_hold_arbiter #(
    .NREQ      (4),
    .MAX_BURST (4)
  ) dut (
    .CLK    (clk),
    .RESET  (rst),
    .bus_io (bus_if.slave)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       hlda;
    logic       hold;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       perr;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic r, logic [3:0] q, logic a, logic h, logic [3:0] g,
                              logic [1:0] o, logic b, logic p);
    vec_t v;
    v.rst = r; v.req = q; v.hlda = a;
    v.hold = h; v.gnt = g; v.owner = o; v.busy = b; v.perr = p;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are read 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (bus_if.gnt != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit   ok;
    int   cnt;
    logic [1:0] rr_exp [4];
    logic [3:0] exp_gnt;

    bus_if.req  = '0;
    bus_if.HLDA = 1'b0;

    //                rst  req     hlda hold gnt     own  busy perr
    // Single requester on req[2]
    vecs[0]  = mk(1, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0);
    vecs[1]  = mk(0, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0);
    vecs[2]  = mk(0, 4'b0100, 0, 1, 4'b0000, 2'd0, 1, 0);
    vecs[3]  = mk(0, 4'b0100, 0, 1, 4'b0000, 2'd0, 1, 0);
    vecs[4]  = mk(0, 4'b0100, 1, 1, 4'b0100, 2'd2, 1, 0);
    vecs[5]  = mk(0, 4'b0100, 1, 1, 4'b0100, 2'd2, 1, 0);
    vecs[6]  = mk(0, 4'b0000, 1, 0, 4'b0000, 2'd2, 1, 0);
    vecs[7]  = mk(0, 4'b0100, 1, 0, 4'b0000, 2'd2, 1, 0);
    vecs[8]  = mk(0, 4'b0100, 0, 0, 4'b0000, 2'd2, 0, 0);
    vecs[9]  = mk(0, 4'b0100, 0, 1, 4'b0000, 2'd2, 1, 0);
    // ptr is 3 now: req[0] wins by wrapping
    vecs[10] = mk(0, 4'b0001, 1, 1, 4'b0001, 2'd0, 1, 0);
    vecs[11] = mk(0, 4'b0000, 1, 0, 4'b0000, 2'd0, 1, 0);
    vecs[12] = mk(0, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0);
    // Withdrawal before HLDA
    vecs[13] = mk(0, 4'b1000, 0, 1, 4'b0000, 2'd0, 1, 0);
    vecs[14] = mk(0, 4'b0000, 0, 1, 4'b0000, 2'd0, 1, 0);
    vecs[15] = mk(0, 4'b0000, 1, 0, 4'b0000, 2'd0, 1, 0);
    vecs[16] = mk(0, 4'b0000, 1, 0, 4'b0000, 2'd0, 1, 0);
    vecs[17] = mk(0, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0);
    // Protocol error: HLDA drops during GRANT; proto_err is sticky
    vecs[18] = mk(0, 4'b0010, 0, 1, 4'b0000, 2'd0, 1, 0);
    vecs[19] = mk(0, 4'b0010, 1, 1, 4'b0010, 2'd1, 1, 0);
    vecs[20] = mk(0, 4'b0010, 0, 0, 4'b0000, 2'd1, 1, 1);
    vecs[21] = mk(0, 4'b0010, 0, 0, 4'b0000, 2'd1, 0, 1);
    vecs[22] = mk(0, 4'b0010, 0, 1, 4'b0000, 2'd1, 1, 1);
    vecs[23] = mk(0, 4'b0010, 1, 1, 4'b0010, 2'd1, 1, 1);
    // Reset mid-GRANT, then lowest pending index wins from ptr=0
    vecs[24] = mk(1, 4'b0010, 1, 0, 4'b0000, 2'd0, 0, 0);
    vecs[25] = mk(0, 4'b1010, 0, 1, 4'b0000, 2'd0, 1, 0);
    vecs[26] = mk(0, 4'b1010, 1, 1, 4'b0010, 2'd1, 1, 0);
    vecs[27] = mk(0, 4'b1000, 1, 0, 4'b0000, 2'd1, 1, 0);
    vecs[28] = mk(0, 4'b0000, 0, 0, 4'b0000, 2'd1, 0, 0);

    #2;
    for (int i = 0; i < NVEC; i++) begin
      rst         = vecs[i].rst;
      bus_if.req  = vecs[i].req;
      bus_if.HLDA = vecs[i].hlda;
      step();
      chk($sformatf("v%0d.HOLD", i),      32'(bus_if.HOLD),      32'(vecs[i].hold));
      chk($sformatf("v%0d.gnt", i),       32'(bus_if.gnt),       32'(vecs[i].gnt));
      chk($sformatf("v%0d.owner", i),     32'(bus_if.owner),     32'(vecs[i].owner));
      chk($sformatf("v%0d.bus_busy", i),  32'(bus_if.bus_busy),  32'(vecs[i].busy));
      chk($sformatf("v%0d.proto_err", i), 32'(bus_if.proto_err), 32'(vecs[i].perr));
    end

    // Round-robin with req=1011 held (owner drops briefly to end its tenure).
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd3; rr_exp[3] = 2'd0;
    rst = 1'b1; bus_if.req = '0; bus_if.HLDA = 1'b0;
    step();
    rst = 1'b0; bus_if.req = 4'b1011;
    step();
    chk("rr.hold_up", 32'(bus_if.HOLD), 32'd1);
    for (int t = 0; t < 4; t++) begin
      bus_if.HLDA = 1'b1;
      wait_gnt(10, ok);
      chk($sformatf("rr%0d.granted", t), 32'(ok), 32'd1);
      exp_gnt = 4'b0001 << rr_exp[t];
      chk($sformatf("rr%0d.owner", t), 32'(bus_if.owner), 32'(rr_exp[t]));
      chk($sformatf("rr%0d.gnt", t), 32'(bus_if.gnt), 32'(exp_gnt));
      step();
      step();
      bus_if.req = 4'b1011 & ~exp_gnt;
      step();
      chk($sformatf("rr%0d.rel_hold", t), 32'(bus_if.HOLD), 32'd0);
      chk($sformatf("rr%0d.rel_gnt", t), 32'(bus_if.gnt), 32'd0);
      bus_if.req = 4'b1011;
      step();
      chk($sformatf("rr%0d.hold_low_hlda", t), 32'(bus_if.HOLD), 32'd0);
      bus_if.HLDA = 1'b0;
      step();
      chk($sformatf("rr%0d.idle", t), 32'(bus_if.bus_busy), 32'd0);
      step();
      chk($sformatf("rr%0d.rehold", t), 32'(bus_if.HOLD), 32'd1);
    end

    // Burst behaviour on req[1].
    rst = 1'b1; bus_if.req = '0; bus_if.HLDA = 1'b0;
    step();
    rst = 1'b0; bus_if.req = 4'b0010;
    step();
    bus_if.HLDA = 1'b1;
    step();
    cnt = 0;
    while (bus_if.gnt[1] && cnt < 110) begin
      cnt++;
      step();
    end
`ifdef HOLD_BURST_LIMIT_EN
    chk("burst.cycles", 32'(cnt), 32'd4);
    chk("burst.hold", 32'(bus_if.HOLD), 32'd0);
`else
    chk("burst.unlimited", 32'(cnt >= 100), 32'd1);
    chk("burst.hold", 32'(bus_if.HOLD), 32'd1);
`endif
    chk("burst.perr", 32'(bus_if.proto_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
